// File: rtl/dot_pkg.sv
// dot_pkg: shared constants for the dot collision stage.
// Holds dot count, fixed dot coordinates and the collider FSM state type.
package dot_pkg;

   localparam int NUM_DOTS = 10;

   typedef logic [9:0] coord_t;

   // Dots sit on one row: x = 64 + 48*i, y = 240.
   localparam coord_t DOT_X [NUM_DOTS] = '{
      10'd64,  10'd112, 10'd160, 10'd208, 10'd256,
      10'd304, 10'd352, 10'd400, 10'd448, 10'd496
   };

   localparam coord_t DOT_Y [NUM_DOTS] = '{default: 10'd240};

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      SETTLE,
      CHECK
   } state_t;

endpackage

// File: rtl/dot_hit_test.sv
// dot_hit_test: one-axis window compare, |a - b| <= HIT_RADIUS.
// Ports: a, b (10-bit pixel coords) in; hit out (combinational).
module dot_hit_test #(
   parameter int HIT_RADIUS = 4
) (
   input  logic [9:0] a,
   input  logic [9:0] b,
   output logic       hit
);

   localparam logic [10:0] RADIUS = 11'(HIT_RADIUS);

   logic [10:0] diff;
   logic [10:0] mag;

   // 11-bit two's-complement difference; bit 10 is the sign.
   assign diff = {1'b0, a} - {1'b0, b};
   assign mag  = diff[10] ? (~diff + 11'd1) : diff;
   assign hit  = (mag <= RADIUS);

endmodule

// File: rtl/dot_collider.sv
// dot_collider: per-frame scan of all dots against the latched Pac-Man
// position; pulses kill_10/eat_pulse per hit, keeps a saturating score
// and a sticky level_clear.
// Ports: Clk, Reset (async, active-high), frame_start, pac_x, pac_y,
// alive_10 in; kill_10, eat_pulse, score, level_clear, busy out.
module dot_collider
   import dot_pkg::*;
#(
   parameter int HIT_RADIUS = 4,
   parameter int DOT_POINTS = 10
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_start,
   input  logic [9:0]  pac_x,
   input  logic [9:0]  pac_y,
   input  logic [9:0]  alive_10,
   output logic [9:0]  kill_10,
   output logic        eat_pulse,
   output logic [15:0] score,
   output logic        level_clear,
   output logic        busy
);

   state_t      state;
   state_t      state_nx;
   logic [3:0]  idx;
   logic        start_q;
   logic [9:0]  px;
   logic [9:0]  py;
   logic        arm;
   coord_t      dot_x;
   coord_t      dot_y;
   logic        dot_alive;
   logic        hit_x;
   logic        hit_y;
   logic        hit;
   logic [16:0] sum;
   logic [15:0] score_nx;

   // frame_start is registered first so the position latch and the
   // scan start are one cycle apart; that arming cycle counts as busy.
   assign arm = frame_start && (state == IDLE) && !start_q;

   always_comb begin
      dot_x     = '0;
      dot_y     = '0;
      dot_alive = 1'b0;
      for (int i = 0; i < NUM_DOTS; i++) begin
         if (idx == 4'(i)) begin
            dot_x     = DOT_X[i];
            dot_y     = DOT_Y[i];
            dot_alive = alive_10[i];
         end
      end
   end

   dot_hit_test #(.HIT_RADIUS(HIT_RADIUS)) u_hit_x (
      .a   (px),
      .b   (dot_x),
      .hit (hit_x)
   );

   dot_hit_test #(.HIT_RADIUS(HIT_RADIUS)) u_hit_y (
      .a   (py),
      .b   (dot_y),
      .hit (hit_y)
   );

   assign hit = (state == SCAN) && dot_alive && hit_x && hit_y;

   assign sum      = {1'b0, score} + 17'(DOT_POINTS);
   assign score_nx = sum[16] ? 16'hFFFF : sum[15:0];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:   if (start_q) state_nx = SCAN;
         SCAN:   if (idx == 4'd9) state_nx = SETTLE;
         SETTLE: state_nx = CHECK;
         CHECK:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         start_q     <= 1'b0;
         px          <= '0;
         py          <= '0;
         idx         <= '0;
         kill_10     <= '0;
         eat_pulse   <= 1'b0;
         score       <= '0;
         level_clear <= 1'b0;
      end else begin
         start_q <= arm;
         if (arm) begin
            px <= pac_x;
            py <= pac_y;
         end
         if (state == SCAN) begin
            idx <= idx + 4'd1;
         end else begin
            idx <= '0;
         end
         kill_10   <= hit ? (10'd1 << idx) : 10'd0;
         eat_pulse <= hit;
         if (hit) begin
            score <= score_nx;
         end
         if ((state == CHECK) && (alive_10 == 10'd0)) begin
            level_clear <= 1'b1;
         end
      end
   end

   assign busy = (state != IDLE) || start_q;

endmodule

// File: tb/tb_dot_collider.sv
// tb_dot_collider: directed frames against dot_collider with a small
// dots-bank model; a second instance checks score saturation.
module tb_dot_collider;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_start;
   logic [9:0]  pac_x;
   logic [9:0]  pac_y;
   logic [9:0]  alive;
   logic        revive;
   logic [9:0]  kill;
   logic        eat;
   logic [15:0] score;
   logic        level;
   logic        busy;

   logic [9:0]  s_alive;
   logic [9:0]  s_kill;
   logic        s_eat;
   logic [15:0] s_score;
   logic        s_level;
   logic        s_busy;

   int nvec = 0;
   int nerr = 0;
   int fnum = 0;

   always #5 clk = ~clk;

   dot_collider dut (
      .Clk         (clk),
      .Reset       (rst),
      .frame_start (frame_start),
      .pac_x       (pac_x),
      .pac_y       (pac_y),
      .alive_10    (alive),
      .kill_10     (kill),
      .eat_pulse   (eat),
      .score       (score),
      .level_clear (level),
      .busy        (busy)
   );

   dot_collider #(.DOT_POINTS(20000)) dut_sat (
      .Clk         (clk),
      .Reset       (rst),
      .frame_start (frame_start),
      .pac_x       (pac_x),
      .pac_y       (pac_y),
      .alive_10    (s_alive),
      .kill_10     (s_kill),
      .eat_pulse   (s_eat),
      .score       (s_score),
      .level_clear (s_level),
      .busy        (s_busy)
   );

   assign s_alive = 10'h3FF;

   // dots bank: no reset, a kill clears its bit on the next edge
   always @(posedge clk) begin
      if (revive) alive <= 10'h3FF;
      else        alive <= alive & ~kill;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_revive();
      @(negedge clk);
      revive = 1'b1;
      @(negedge clk);
      revive = 1'b0;
   endtask

   task automatic frame_chk(input logic [9:0] x, input logic [9:0] y,
                            input bit extra, input logic [9:0] emask,
                            input int efirst, input logic [15:0] escore,
                            input bit elevel, input logic [15:0] esat);
      logic [9:0] kmask;
      int kfirst;
      int kcyc;
      int bcyc;
      int bad;
      string t;
      kmask  = '0;
      kfirst = -1;
      kcyc   = 0;
      bcyc   = 0;
      bad    = 0;
      fnum++;
      t = $sformatf("f%0d", fnum);
      @(negedge clk);
      pac_x = x;
      pac_y = y;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      // sample k is taken in the cycle after edge E(k)
      for (int k = 0; k < 16; k++) begin
         if (kill != 10'd0) begin
            kmask |= kill;
            if (kfirst < 0) kfirst = k;
            kcyc++;
            if ($countones(kill) != 1) bad++;
         end
         if (eat != (kill != 10'd0)) bad++;
         if (busy) bcyc++;
         if (k == 1) begin
            pac_x = x ^ 10'h155;
            pac_y = y ^ 10'h0AA;
         end
         frame_start = (extra && (k == 4));
         @(negedge clk);
      end
      check({t, ".kill"}, 32'(kmask), 32'(emask));
      check({t, ".first"}, 32'(kfirst), 32'(efirst));
      check({t, ".kcyc"}, 32'(kcyc), (emask != 0) ? 32'd1 : 32'd0);
      check({t, ".busy"}, 32'(bcyc), 32'd13);
      check({t, ".pulse"}, 32'(bad), 32'd0);
      check({t, ".score"}, 32'(score), 32'(escore));
      check({t, ".level"}, 32'(level), 32'(elevel));
      check({t, ".sat"}, 32'(s_score), 32'(esat));
   endtask

   initial begin
      rst         = 1'b1;
      revive      = 1'b1;
      frame_start = 1'b0;
      pac_x       = '0;
      pac_y       = '0;
      repeat (3) @(negedge clk);
      check("rst.kill", 32'(kill), 32'd0);
      check("rst.eat", 32'(eat), 32'd0);
      check("rst.score", 32'(score), 32'd0);
      check("rst.level", 32'(level), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.sat", 32'(s_score), 32'd0);
      rst    = 1'b0;
      revive = 1'b0;
      @(negedge clk);

      // dot 3 at (208,240)
      frame_chk(10'd208, 10'd240, 0, 10'h008, 5, 16'd10, 0, 16'd20000);
      frame_chk(10'd208, 10'd240, 0, 10'h000, -1, 16'd10, 0, 16'd40000);
      do_revive();
      frame_chk(10'd212, 10'd244, 0, 10'h008, 5, 16'd20, 0, 16'd60000);
      do_revive();
      frame_chk(10'd213, 10'd240, 0, 10'h000, -1, 16'd20, 0, 16'd60000);
      frame_chk(10'd208, 10'd245, 0, 10'h000, -1, 16'd20, 0, 16'd60000);
      frame_chk(10'd204, 10'd236, 0, 10'h008, 5, 16'd30, 0, 16'd65535);

      // sweep every dot
      do_revive();
      for (int i = 0; i < 10; i++) begin
         frame_chk(10'(64 + 48 * i), 10'd240, 0, 10'(1 << i), i + 2,
                   16'(30 + 10 * (i + 1)), (i == 9), 16'd65535);
      end

      // all dead, extra frame_start mid-scan is dropped
      frame_chk(10'd496, 10'd240, 1, 10'h000, -1, 16'd130, 1, 16'd65535);
      check("idle.busy", 32'(busy), 32'd0);

      // reset while dot 5 is under evaluation
      do_revive();
      @(negedge clk);
      pac_x = 10'd304;
      pac_y = 10'd240;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      repeat (6) @(negedge clk);
      check("mid.busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("mid.kill", 32'(kill), 32'd0);
      check("mid.eat", 32'(eat), 32'd0);
      check("mid.score", 32'(score), 32'd0);
      check("mid.level", 32'(level), 32'd0);
      check("mid.bsy0", 32'(busy), 32'd0);
      check("mid.sat", 32'(s_score), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post.kill", 32'(kill), 32'd0);
      check("post.busy", 32'(busy), 32'd0);
      frame_chk(10'd64, 10'd240, 0, 10'h001, 2, 16'd10, 0, 16'd20000);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
